// File: rtl/pgx_bus_switch_if.sv
// rtl/pgx_bus_switch_if.sv - request port and gate-enable bundle for pgx_bus_switch
interface pgx_bus_switch_if #(
  parameter int NCH  = 4,
  parameter int SELW = 2
);
  logic            req_valid;
  logic            req_ready;
  logic [SELW-1:0] req_sel;
  logic            req_off;
  logic            kill;
  logic [NCH-1:0]  en_n;
  logic [NCH-1:0]  en_p;
  logic [SELW-1:0] cur_sel;
  logic            cur_valid;
  logic            busy;
  logic            done;
  logic            err;
  logic            abort;

  // Arbitration side: issues requests and kill, observes the gate bank state.
  modport master (
    output req_valid, req_sel, req_off, kill,
    input  req_ready, en_n, en_p, cur_sel, cur_valid, busy, done, err, abort
  );

  // Switch side: sequences the gate enables.
  modport slave (
    input  req_valid, req_sel, req_off, kill,
    output req_ready, en_n, en_p, cur_sel, cur_valid, busy, done, err, abort
  );
endinterface

// File: rtl/pgx_bus_switch.sv
// rtl/pgx_bus_switch.sv - break-before-make sequencer for NCH pass-gate channels on one bus
module pgx_bus_switch #(
  parameter int NCH        = 4,
  parameter int SELW       = 2,
  parameter int DEAD_CYC   = 2,
  parameter int SETTLE_CYC = 1
) (
  input logic              clk,
  input logic              rst,
  pgx_bus_switch_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BREAK,
    ST_DEAD,
    ST_SETTLE
  } state_t;

  localparam logic [SELW:0] NCH_LIM     = (SELW+1)'(NCH);
  localparam logic [3:0]    DEAD_LOAD   = 4'(DEAD_CYC - 1);
  localparam logic [3:0]    SETTLE_LOAD = 4'(SETTLE_CYC - 1);

  state_t          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [NCH-1:0]  en_q, en_d;
  logic [SELW-1:0] cur_sel_q, cur_sel_d;
  logic            cur_valid_q, cur_valid_d;
  logic            busy_q, busy_d;
  logic            ready_q, ready_d;
  logic            done_q, done_d;
  logic            err_q, err_d;
  logic            abort_q, abort_d;
  logic            imm_done_q, imm_done_d;
  logic            imm_err_q, imm_err_d;
  logic [SELW-1:0] tgt_sel_q, tgt_sel_d;
  logic            tgt_off_q, tgt_off_d;

  logic            accept;
  logic            sel_bad;
  logic            same_target;
  logic [NCH-1:0]  tgt_onehot;

  assign accept      = bus.req_valid & ready_q & ~bus.kill;
  assign sel_bad     = ({1'b0, bus.req_sel} >= NCH_LIM) & ~bus.req_off;
  assign same_target = bus.req_off ? ~cur_valid_q
                                   : (cur_valid_q & (bus.req_sel == cur_sel_q));

  // Decode the captured target channel into its single gate enable.
  always_comb begin
    tgt_onehot = '0;
    for (int i = 0; i < NCH; i++) begin
      if (tgt_sel_q == SELW'(i)) tgt_onehot[i] = 1'b1;
    end
  end

  // Next-state and next-output logic; kill overrides every sequencing decision.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    en_d        = en_q;
    cur_sel_d   = cur_sel_q;
    cur_valid_d = cur_valid_q;
    busy_d      = busy_q;
    ready_d     = ready_q;
    done_d      = imm_done_q;
    err_d       = imm_err_q;
    abort_d     = 1'b0;
    imm_done_d  = 1'b0;
    imm_err_d   = 1'b0;
    tgt_sel_d   = tgt_sel_q;
    tgt_off_d   = tgt_off_q;

    if (bus.kill) begin
      // Pending immediate answers are dropped too: nothing completes across a kill.
      state_d     = ST_IDLE;
      cnt_d       = 4'd0;
      en_d        = '0;
      cur_valid_d = 1'b0;
      busy_d      = 1'b0;
      ready_d     = 1'b1;
      done_d      = 1'b0;
      err_d       = 1'b0;
      abort_d     = busy_q;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (accept) begin
            if (sel_bad) begin
              imm_err_d = 1'b1;
            end else if (same_target) begin
              // Already in the requested state: answer without touching the gates.
              imm_done_d = 1'b1;
            end else begin
              tgt_sel_d = bus.req_sel;
              tgt_off_d = bus.req_off;
              state_d   = ST_BREAK;
              busy_d    = 1'b1;
              ready_d   = 1'b0;
            end
          end
        end
        ST_BREAK: begin
          en_d        = '0;
          cur_valid_d = 1'b0;
          cnt_d       = DEAD_LOAD;
          state_d     = ST_DEAD;
        end
        ST_DEAD: begin
          if (cnt_q != 4'd0) begin
            cnt_d = cnt_q - 4'd1;
          end else if (tgt_off_q) begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            ready_d = 1'b1;
            state_d = ST_IDLE;
          end else begin
            en_d        = tgt_onehot;
            cur_sel_d   = tgt_sel_q;
            cur_valid_d = 1'b1;
            if (SETTLE_CYC == 0) begin
              done_d  = 1'b1;
              busy_d  = 1'b0;
              ready_d = 1'b1;
              state_d = ST_IDLE;
            end else begin
              cnt_d   = SETTLE_LOAD;
              state_d = ST_SETTLE;
            end
          end
        end
        ST_SETTLE: begin
          if (cnt_q != 4'd0) begin
            cnt_d = cnt_q - 4'd1;
          end else begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            ready_d = 1'b1;
            state_d = ST_IDLE;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // State and output registers; reset silently abandons any sequence in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 4'd0;
      en_q        <= '0;
      cur_sel_q   <= '0;
      cur_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      ready_q     <= 1'b1;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      abort_q     <= 1'b0;
      imm_done_q  <= 1'b0;
      imm_err_q   <= 1'b0;
      tgt_sel_q   <= '0;
      tgt_off_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      en_q        <= en_d;
      cur_sel_q   <= cur_sel_d;
      cur_valid_q <= cur_valid_d;
      busy_q      <= busy_d;
      ready_q     <= ready_d;
      done_q      <= done_d;
      err_q       <= err_d;
      abort_q     <= abort_d;
      imm_done_q  <= imm_done_d;
      imm_err_q   <= imm_err_d;
      tgt_sel_q   <= tgt_sel_d;
      tgt_off_q   <= tgt_off_d;
    end
  end

  // Kill masks ready in the very cycle it is presented so no request slips in.
  assign bus.req_ready = ready_q & ~bus.kill;
  assign bus.en_n      = en_q;
  assign bus.en_p      = ~en_q;
  assign bus.cur_sel   = cur_sel_q;
  assign bus.cur_valid = cur_valid_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign bus.abort     = abort_q;

endmodule

// File: tb/tb_pgx_bus_switch.sv
// tb/tb_pgx_bus_switch.sv - self-checking bench for pgx_bus_switch
module tb_pgx_bus_switch;

  localparam int NCH        = 4;
  localparam int SELW       = 3;
  localparam int DEAD_CYC   = 2;
  localparam int SETTLE_CYC = 1;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  pgx_bus_switch_if #(.NCH(NCH), .SELW(SELW)) bus ();

  pgx_bus_switch #(
    .NCH(NCH), .SELW(SELW), .DEAD_CYC(DEAD_CYC), .SETTLE_CYC(SETTLE_CYC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic       err;
    int         lat;
    int         acc;
    logic [3:0] en;
    logic       cv;
    logic [2:0] cs;
  } sb_t;

  typedef struct {
    logic        off;
    logic [2:0]  sel;
    logic        err;
    int          lat;
    logic [19:0] trace;
    logic [3:0]  en;
    logic        cv;
    logic [2:0]  cs;
  } vec_t;

  sb_t  sb[$];
  sb_t  mon_e;
  vec_t vecs[11];

  int cyc      = 0;
  int total    = 0;
  int passed   = 0;
  int inv_viol = 0;
  bit inv_en   = 1'b0;
  bit sb_en    = 1'b1;
  bit abort_ok = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
  endtask

  // Gate invariants every cycle, plus scoreboard pop on each DONE/ERR pulse.
  always @(negedge clk) begin
    if (inv_en) begin
      if (bus.en_p !== ~bus.en_n) inv_viol++;
      if ($countones(bus.en_n) > 1) inv_viol++;
      if (bus.cur_valid !== (|bus.en_n)) inv_viol++;
    end
    if (sb_en && bus.abort === 1'b1 && !abort_ok)
      check("unexpected_abort", {31'd0, bus.abort}, 32'd0);
    if (sb_en && (bus.done === 1'b1 || bus.err === 1'b1)) begin
      if (sb.size() == 0) begin
        check("unexpected_pulse", {30'd0, bus.done, bus.err}, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check("pulse_kind", {30'd0, bus.done, bus.err}, {30'd0, ~mon_e.err, mon_e.err});
        check("latency", cyc - mon_e.acc, mon_e.lat);
        check("final_en_n", {28'd0, bus.en_n}, {28'd0, mon_e.en});
        check("final_cur_valid", {31'd0, bus.cur_valid}, {31'd0, mon_e.cv});
        check("final_cur_sel", {29'd0, bus.cur_sel}, {29'd0, mon_e.cs});
      end
    end
  end

  task automatic run_vec(input vec_t v, input int idx);
    int  n;
    sb_t e;
    n = 0;
    while (bus.req_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check($sformatf("v%0d_ready", idx), {31'd0, bus.req_ready}, 32'd1);
    bus.req_valid = 1'b1;
    bus.req_sel   = v.sel;
    bus.req_off   = v.off;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.req_sel   = ~v.sel;
    bus.req_off   = ~v.off;
    e.err = v.err; e.lat = v.lat; e.acc = cyc; e.en = v.en; e.cv = v.cv; e.cs = v.cs;
    sb.push_back(e);
    for (int k = 0; k < 5; k++) begin
      if (k > 0) @(negedge clk);
      check($sformatf("v%0d_trace%0d", idx, k), {28'd0, bus.en_n}, {28'd0, v.trace[19-4*k -: 4]});
    end
    @(negedge clk);
    n = 0;
    while (sb.size() != 0 && n < 10) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      check($sformatf("v%0d_done_timeout", idx), sb.size(), 32'd0);
      sb.delete();
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // en_n trace: one hex digit per negedge sample after acceptance edges T..T+4.
    vecs[0]  = '{off:1'b0, sel:3'd2, err:1'b0, lat:4, trace:20'h00044, en:4'h4, cv:1'b1, cs:3'd2};
    vecs[1]  = '{off:1'b0, sel:3'd1, err:1'b0, lat:4, trace:20'h40022, en:4'h2, cv:1'b1, cs:3'd1};
    vecs[2]  = '{off:1'b0, sel:3'd1, err:1'b0, lat:1, trace:20'h22222, en:4'h2, cv:1'b1, cs:3'd1};
    vecs[3]  = '{off:1'b0, sel:3'd5, err:1'b1, lat:1, trace:20'h22222, en:4'h2, cv:1'b1, cs:3'd1};
    vecs[4]  = '{off:1'b0, sel:3'd4, err:1'b1, lat:1, trace:20'h22222, en:4'h2, cv:1'b1, cs:3'd1};
    vecs[5]  = '{off:1'b0, sel:3'd3, err:1'b0, lat:4, trace:20'h20088, en:4'h8, cv:1'b1, cs:3'd3};
    vecs[6]  = '{off:1'b1, sel:3'd6, err:1'b0, lat:3, trace:20'h80000, en:4'h0, cv:1'b0, cs:3'd3};
    vecs[7]  = '{off:1'b1, sel:3'd6, err:1'b0, lat:1, trace:20'h00000, en:4'h0, cv:1'b0, cs:3'd3};
    vecs[8]  = '{off:1'b0, sel:3'd0, err:1'b0, lat:4, trace:20'h00011, en:4'h1, cv:1'b1, cs:3'd0};
    vecs[9]  = '{off:1'b0, sel:3'd7, err:1'b1, lat:1, trace:20'h11111, en:4'h1, cv:1'b1, cs:3'd0};
    vecs[10] = '{off:1'b0, sel:3'd0, err:1'b0, lat:1, trace:20'h11111, en:4'h1, cv:1'b1, cs:3'd0};

    rst = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_sel   = '0;
    bus.req_off   = 1'b0;
    bus.kill      = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_en_n", {28'd0, bus.en_n}, 32'h0);
    check("rst_en_p", {28'd0, bus.en_p}, 32'hf);
    check("rst_cur_valid", {31'd0, bus.cur_valid}, 32'd0);
    check("rst_cur_sel", {29'd0, bus.cur_sel}, 32'd0);
    check("rst_ready", {31'd0, bus.req_ready}, 32'd1);
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_pulses", {29'd0, bus.done, bus.err, bus.abort}, 32'd0);
    rst = 1'b0;
    inv_en = 1'b1;

    for (int i = 0; i < 11; i++) run_vec(vecs[i], i);

    // Kill during DEAD while moving ch0 -> ch2.
    abort_ok = 1'b1;
    bus.req_valid = 1'b1; bus.req_sel = 3'd2; bus.req_off = 1'b0;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("kill_pre_en_n", {28'd0, bus.en_n}, 32'h0);
    check("kill_pre_busy", {31'd0, bus.busy}, 32'd1);
    bus.kill = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.kill = 1'b0;
    #1;
    check("kill_abort", {31'd0, bus.abort}, 32'd1);
    check("kill_en_n", {28'd0, bus.en_n}, 32'h0);
    check("kill_cur_valid", {31'd0, bus.cur_valid}, 32'd0);
    check("kill_busy", {31'd0, bus.busy}, 32'd0);
    check("kill_ready", {31'd0, bus.req_ready}, 32'd1);
    abort_ok = 1'b0;
    @(negedge clk);
    check("kill_abort_one_cycle", {31'd0, bus.abort}, 32'd0);
    repeat (5) @(negedge clk);

    // Kill held together with a valid request: never accepted.
    bus.kill = 1'b1; bus.req_valid = 1'b1; bus.req_sel = 3'd1; bus.req_off = 1'b0;
    #1;
    check("kill_hold_ready", {31'd0, bus.req_ready}, 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("kill_hold_busy", {31'd0, bus.busy}, 32'd0);
    check("kill_hold_en_n", {28'd0, bus.en_n}, 32'h0);
    bus.req_valid = 1'b0;
    bus.kill      = 1'b0;
    repeat (3) @(negedge clk);

    // Reset during SETTLE with ch0 already driven.
    bus.req_valid = 1'b1; bus.req_sel = 3'd0; bus.req_off = 1'b0;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("settle_en_n", {28'd0, bus.en_n}, 32'h1);
    check("settle_busy", {31'd0, bus.busy}, 32'd1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("midrst_en_n", {28'd0, bus.en_n}, 32'h0);
    check("midrst_en_p", {28'd0, bus.en_p}, 32'hf);
    check("midrst_busy", {31'd0, bus.busy}, 32'd0);
    check("midrst_pulses", {29'd0, bus.done, bus.err, bus.abort}, 32'd0);
    check("midrst_ready", {31'd0, bus.req_ready}, 32'd1);
    repeat (5) @(negedge clk);

    // Random request/kill stream; only the gate invariants are judged here.
    sb_en = 1'b0;
    for (int c = 0; c < 10000; c++) begin
      bus.req_valid = 1'($urandom_range(0, 1));
      bus.req_sel   = 3'($urandom_range(0, 7));
      bus.req_off   = ($urandom_range(0, 7) == 0);
      bus.kill      = ($urandom_range(0, 31) == 0);
      @(negedge clk);
    end
    bus.req_valid = 1'b0;
    bus.kill      = 1'b0;
    repeat (20) @(negedge clk);
    check("gate_invariants", inv_viol, 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
